// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4-channel TDM receiver.
// Holds the slot count, the framer state enum and the slot index type.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_slot_shifter.sv
// tdm_slot_shifter: serial-in shift register with a per-slot bit counter.
// Ports: clk, reset (sync, high), clr (drop partial slot), start (din is
//   the slot MSB, count 1), step (shift din, count up), din;
//   word = {history, din}, first (count==0), last (count==SLOT_BITS-1).
module tdm_slot_shifter #(
  parameter int SLOT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 step,
  input  logic                 din,
  output logic [SLOT_BITS-1:0] word,
  output logic                 first,
  output logic                 last
);

  localparam int SW = SLOT_BITS - 1;
  localparam int CW = $clog2(SLOT_BITS);

  logic [SW-1:0] sh;
  logic [CW-1:0] cnt;

  // The slot's last bit is not stored; it joins the word combinationally.
  assign word  = {sh, din};
  assign first = (cnt == '0);
  assign last  = (cnt == CW'(SLOT_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= SW'(din);
      cnt <= CW'(1);
    end else if (step) begin
      sh  <= word[SW-1:0];
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot serial TDM receiver with frame lock and re-acquire.
// Ports: clk, reset (sync, high), din, din_en, frame_sync; ch0..3_data,
//   ch_valid, parity_err, sync_err, locked.
// Build option: PARITY_CHECK_EN adds one even-parity bit after each slot.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 din_en,
  input  logic                 frame_sync,
  output logic [WIDTH-1:0]     ch0_data,
  output logic [WIDTH-1:0]     ch1_data,
  output logic [WIDTH-1:0]     ch2_data,
  output logic [WIDTH-1:0]     ch3_data,
  output logic [NUM_SLOTS-1:0] ch_valid,
  output logic [NUM_SLOTS-1:0] parity_err,
  output logic                 sync_err,
  output logic                 locked
);

`ifdef PARITY_CHECK_EN
  localparam int SLOT_BITS = WIDTH + 1;
`else
  localparam int SLOT_BITS = WIDTH;
`endif

  state_t state, state_n;
  slot_t  slot_cnt, slot_n;

  logic [SLOT_BITS-1:0] word;
  logic [WIDTH-1:0]     data;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic [WIDTH-1:0]     ch_q [NUM_SLOTS];

  logic first, last, at_sync, bad_par;
  logic sh_clr, sh_start, sh_step;
  logic load, serr;

  tdm_slot_shifter #(
    .SLOT_BITS(SLOT_BITS)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .clr  (sh_clr),
    .start(sh_start),
    .step (sh_step),
    .din  (din),
    .word (word),
    .first(first),
    .last (last)
  );

`ifdef PARITY_CHECK_EN
  // Trailing bit is parity; odd total weight means even parity failed.
  assign data    = word[SLOT_BITS-1:1];
  assign bad_par = ^word;
`else
  assign data    = word;
  assign bad_par = 1'b0;
`endif

  assign at_sync = first && (slot_cnt == '0);
  assign slot_oh = NUM_SLOTS'(1) << slot_cnt;

  always_comb begin
    state_n  = state;
    slot_n   = slot_cnt;
    sh_clr   = 1'b0;
    sh_start = 1'b0;
    sh_step  = 1'b0;
    load     = 1'b0;
    serr     = 1'b0;
    if (din_en) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            sh_start = 1'b1;
            slot_n   = '0;
            state_n  = RUN;
          end
        end
        RUN: begin
          unique case (1'b1)
            (at_sync && !frame_sync): begin
              serr    = 1'b1;
              sh_clr  = 1'b1;
              state_n = HUNT;
            end
            // Early sync: drop partial slot, restart at slot 0.
            (frame_sync && !at_sync): begin
              serr     = 1'b1;
              sh_start = 1'b1;
              slot_n   = '0;
            end
            default: begin
              sh_step = 1'b1;
              if (last) begin
                load   = 1'b1;
                slot_n = slot_t'(slot_cnt + 2'd1);
              end
            end
          endcase
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      ch_valid   <= '0;
      parity_err <= '0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      slot_cnt   <= slot_n;
      ch_valid   <= load ? slot_oh : '0;
      parity_err <= (load && bad_par) ? slot_oh : '0;
      sync_err   <= serr;
      locked     <= (state_n == RUN);
      if (load) begin
        ch_q[slot_cnt] <= data;
      end
    end
  end

  assign ch0_data = ch_q[0];
  assign ch1_data = ch_q[1];
  assign ch2_data = ch_q[2];
  assign ch3_data = ch_q[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4 (WIDTH=8).
// Works with or without PARITY_CHECK_EN defined.
module tb_tdm_demux4;

  localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
  localparam int SB = WIDTH + 1;
`else
  localparam int SB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             din;
  logic             din_en;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic [3:0]       ch_valid;
  logic [3:0]       parity_err;
  logic             sync_err;
  logic             locked;

  int n_cmp = 0;
  int n_mis = 0;

  tdm_demux4 #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_en    (din_en),
    .frame_sync(frame_sync),
    .ch0_data  (ch0_data),
    .ch1_data  (ch1_data),
    .ch2_data  (ch2_data),
    .ch3_data  (ch3_data),
    .ch_valid  (ch_valid),
    .parity_err(parity_err),
    .sync_err  (sync_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic fs, input logic en);
    @(negedge clk);
    din        = b;
    frame_sync = fs;
    din_en     = en;
    @(posedge clk);
    #1;
  endtask

  // Sends one slot (data + parity bit when enabled), checking each bit.
  task automatic send_slot(input logic [WIDTH-1:0] w, input logic fs,
                           input logic se, input logic [3:0] ev,
                           input logic gap, input logic wrong);
    logic [SB-1:0] bits;
    logic [3:0]    pe;
`ifdef PARITY_CHECK_EN
    bits = {w, (^w) ^ wrong};
    pe   = wrong ? ev : 4'b0;
`else
    bits = w;
    pe   = 4'b0;
`endif
    for (int i = SB - 1; i >= 0; i--) begin
      step(bits[i], fs && (i == SB - 1), 1'b1);
      chk("ch_valid", ch_valid, (i == 0) ? ev : 4'b0);
      chk("parity_err", parity_err, (i == 0) ? pe : 4'b0);
      chk("sync_err", sync_err, (i == SB - 1) ? se : 1'b0);
      chk("locked", locked, 1'b1);
      if (gap) begin
        step(1'b0, 1'b0, 1'b0);
        chk("gap_valid", ch_valid, 4'b0);
      end
    end
  endtask

  initial begin
    int bad;
    reset      = 1'b1;
    din        = 1'b0;
    din_en     = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ch0", ch0_data, 8'h00);
    chk("rst_ch3", ch3_data, 8'h00);
    chk("rst_valid", ch_valid, 4'b0);
    chk("rst_perr", parity_err, 4'b0);
    chk("rst_serr", sync_err, 1'b0);
    chk("rst_locked", locked, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // frame_sync without strobe must not lock
    step(1'b1, 1'b1, 1'b0);
    chk("no_en_lock", locked, 1'b0);

    // lock and decode
    send_slot(8'hA5, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    send_slot(8'h3C, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
    send_slot(8'hFF, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
    send_slot(8'h01, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);
    chk("f1_ch0", ch0_data, 8'hA5);
    chk("f1_ch1", ch1_data, 8'h3C);
    chk("f1_ch2", ch2_data, 8'hFF);
    chk("f1_ch3", ch3_data, 8'h01);

    // gapped strobe, different words so loads are visible
    send_slot(8'h81, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
    send_slot(8'h42, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0);
    send_slot(8'h24, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0);
    send_slot(8'h18, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
    chk("gap_ch0", ch0_data, 8'h81);
    chk("gap_ch1", ch1_data, 8'h42);
    chk("gap_ch2", ch2_data, 8'h24);
    chk("gap_ch3", ch3_data, 8'h18);

    // missing sync at slot0/bit0
    step(1'b1, 1'b0, 1'b1);
    chk("miss_serr", sync_err, 1'b1);
    chk("miss_locked", locked, 1'b0);
    chk("miss_valid", ch_valid, 4'b0);
    bad = 0;
    for (int i = 0; i < 4 * SB - 1; i++) begin
      step(i[0], 1'b0, 1'b1);
      if (ch_valid != 4'b0 || sync_err || locked) bad++;
    end
    chk("hunt_quiet", bad, 0);
    chk("hold_ch0", ch0_data, 8'h81);
    chk("hold_ch3", ch3_data, 8'h18);

    // relock, then early sync at slot 1 bit 3
    send_slot(8'h66, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    send_slot(8'h5A, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    chk("early_ch0", ch0_data, 8'h5A);
    chk("early_ch1", ch1_data, 8'h42);

    // reset in the middle of slot 2
    send_slot(8'h77, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
    chk("pre_rst_ch1", ch1_data, 8'h77);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_ch0", ch0_data, 8'h00);
    chk("mrst_ch1", ch1_data, 8'h00);
    chk("mrst_ch2", ch2_data, 8'h00);
    chk("mrst_ch3", ch3_data, 8'h00);
    chk("mrst_locked", locked, 1'b0);
    chk("mrst_valid", ch_valid, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 2 * SB; i++) begin
      step(~i[0], 1'b0, 1'b1);
      if (ch_valid != 4'b0 || sync_err || locked) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    // relock; slot 0 carries a wrong parity bit when parity is built in
    send_slot(8'hA5, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1);
    chk("relock_ch0", ch0_data, 8'hA5);
    chk("relock_ch1", ch1_data, 8'h00);
    send_slot(8'hC3, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
    chk("relock_ch1b", ch1_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 channel selector.
- Takes one serial time-division-multiplexed bit stream carrying four channels and reassembles the channel words.
- Each frame is 4 slots of WIDTH bits, MSB first. Slot 0 is marked by frame_sync.
- Completed words are presented on four parallel channel outputs with per-channel valid strobes. Frame-alignment loss is detected and re-acquired automatically.

Parameters:
- WIDTH, 8, data bits per slot (legal range 2..32).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial TDM data bit.
- din_en  input  1  bit strobe. din and frame_sync are sampled only when din_en=1.
- frame_sync  input  1  high together with the first (MSB) bit of slot 0.
- ch0_data  output  WIDTH  last completed word of slot 0.
- ch1_data  output  WIDTH  last completed word of slot 1.
- ch2_data  output  WIDTH  last completed word of slot 2.
- ch3_data  output  WIDTH  last completed word of slot 3.
- ch_valid  output  4  one-cycle pulse; bit n marks a new word on chn_data.
- parity_err  output  4  one-cycle pulse alongside ch_valid[n]; tied 0 unless PARITY_CHECK_EN is defined.
- sync_err  output  1  one-cycle pulse on alignment fault.
- locked  output  1  high while the state is RUN.

Behaviour:
- Reset is synchronous and active-high, one clock domain.
- Reset values: state=HUNT; shift register, bit_cnt and slot_cnt = 0; all chN_data=0; ch_valid=0; parity_err=0; sync_err=0; locked=0.
- Reset asserted mid-frame discards the partial word. The next frame_sync is required to re-lock.
- din_en=0: no state, counter or shift change. frame_sync is ignored. All pulse outputs are 0.
- HUNT:
  - din_en & frame_sync: shift in din, bit_cnt=1, slot_cnt=0, go to RUN.
  - Any other din_en bit is discarded.
- RUN, each din_en bit:
  - Shift in din, MSB first.
  - bit_cnt increments. On the last bit of the slot (bit_cnt == SLOT_BITS-1):
    - load {shift, din} into ch[slot_cnt]_data;
    - assert ch_valid[slot_cnt] for the next cycle;
    - bit_cnt=0, slot_cnt increments, wrapping 3 -> 0.
- SLOT_BITS = WIDTH (WIDTH+1 with parity).
- Latency: chN_data and ch_valid[n] are visible in the cycle after the clock edge that samples the slot's last bit.
- chN_data holds its value until that channel's next completed word.
- Expected sync point is slot_cnt=0 and bit_cnt=0:
  - frame_sync present there: normal frame start, no error.
  - frame_sync absent there: sync_err pulse, locked drops, go to HUNT. The bit is discarded.
  - frame_sync present anywhere else: sync_err pulse, partial slot discarded with no ch_valid. The bit is taken as MSB of slot 0 (bit_cnt=1, slot_cnt=0), stay in RUN, locked stays 1.
- Only one ch_valid bit can be high in any cycle.
- locked is registered and equals (state==RUN).

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - each slot carries WIDTH data bits followed by one even-parity bit;
  - the parity bit is not stored in chN_data;
  - on mismatch, parity_err[slot] pulses in the same cycle as ch_valid[slot];
  - data is still loaded.
- Undefined: the slot is WIDTH bits and parity_err is constant 0.

Decomposition:
- Shared package tdm_pkg:
  - NUM_SLOTS=4;
  - state enum {HUNT, RUN};
  - slot index type (2 bits).
- Natural sub-module: tdm_slot_shifter, containing the shift register, bit counter and a last-bit flag, parameterised by SLOT_BITS. The top level keeps the FSM, slot counter and output registers.

Test Plan:
- Lock and decode, WIDTH=8, din_en always 1: frame_sync, then slots 0xA5, 0x3C, 0xFF, 0x01. Required: locked=1 after the first bit; ch0..3_data = A5, 3C, FF, 01; ch_valid pulses 0001, 0010, 0100, 1000 at cycles 8, 16, 24, 32 after sync.
- Gapped strobe: same frame with din_en toggling 1,0,1,0. Required: identical data; each ch_valid comes one cycle after the last strobed bit.
- Missing sync: second frame sent without frame_sync. Required: sync_err pulses once at slot0/bit0; locked=0; no ch_valid until the next frame_sync; chN_data keep their prior values.
- Early sync: frame_sync at slot 1, bit 3. Required: sync_err pulse; ch1 is not updated; the following 8 bits 0x5A appear on ch0_data with ch_valid=0001.
- Reset mid-slot 2: assert reset for 1 cycle. Required: all data=0, locked=0; no ch_valid until a new frame_sync.
- PARITY_CHECK_EN defined: slot0 = 0xA5 + parity bit 1 (wrong). Required: ch0_data=A5 with ch_valid[0]=1 and parity_err[0]=1; a correct parity bit 0 gives parity_err=0.
